wb_port_arbiter: RTL and testbench
==================================

# wb_port_arbiter

Shares the single register-file write port and the HI/LO write port between the in-order pipeline writeback stage and the out-of-order long-latency unit (multi-cycle mul/div, uncached load return). Pipeline writes have priority. Long-latency results wait in a small pending FIFO. A starvation counter forces a one-cycle pipeline stall so that queued results always drain. The block sits between the writeback stage and the register file / HI-LO registers, and feeds a pending-address query to the hazard unit.

## Interface
- WIDTH, 32, GPR data width
- DEPTH, 2, pending FIFO entries (power of two, ≥2)
- STARVE_LIMIT, 4, cycles the FIFO head may wait before a stall is forced (≥1)

- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- wb_we  in  1  pipeline GPR write request
- wb_addr  in  7  pipeline write address
- wb_data  in  WIDTH  pipeline write data
- wb_hilo_we  in  1  pipeline HI/LO write request
- wb_hilo_data  in  64  pipeline HI/LO data {HI,LO}
- lu_valid  in  1  long-latency result offered
- lu_ready  out  1  result accepted this cycle when lu_valid high
- lu_we  in  1  result writes a GPR
- lu_addr  in  7  result GPR address
- lu_data  in  WIDTH  result GPR data
- lu_hilo_we  in  1  result writes HI/LO
- lu_hilo_data  in  64  result HI/LO data
- rf_we, rf_addr, rf_data  out  1/7/WIDTH  registered GPR write port
- hilo_we, hilo_data  out  1/64  registered HI/LO write port
- stall_req  out  1  asks hazard unit to freeze WB this cycle
- q_addr  in  7  hazard-unit query address
- q_hit  out  1  a queued FIFO entry writes q_addr

## Operation
- FIFO entry = {we, addr, data, hilo_we, hilo_data}. Push when lu_valid && lu_ready. lu_ready = !full && !rst, derived from the current occupancy; a pop in the same cycle does not free a slot.
- Pipeline request present = wb_we || wb_hilo_we.
- Grant, evaluated each cycle:
  - stall_req high and FIFO non-empty → FIFO head.
  - Otherwise, pipeline request present → pipeline.
  - Otherwise, FIFO non-empty → FIFO head.
  - Otherwise no grant; write outputs go to 0 next cycle.
- Granting the FIFO head pops it in that cycle. While stall_req is high, the pipeline request is ignored and is not lost: the hazard unit holds WB and re-presents the request.
- The granted source's fields are registered onto rf_*/hilo_*. rf_we is forced to 0 when the granted address is 0. hilo_we is passed through independently of rf_we.
- Starvation counter: increments each cycle the FIFO is non-empty and the head is not popped. It clears on a pop or when the FIFO is empty, and saturates at STARVE_LIMIT. stall_req = (counter == STARVE_LIMIT), decoded from the register.
- q_hit = OR over valid entries of (entry.we && entry.addr == q_addr && q_addr != 0). Purely combinational.
- Reset clears the FIFO (pending entries are discarded), the counter and all registered outputs.

## Timing
- Reset values: rf_we=0, rf_addr=0, rf_data=0, hilo_we=0, hilo_data=0, stall_req=0, lu_ready=0 while rst is high, q_hit=0.
- Pipeline request to rf_we: 1 cycle.
- LU push in cycle N, with no pipeline traffic: head is granted at N+1, rf_we is visible at N+2. There is no FIFO bypass.
- Continuous pipeline traffic with one entry queued:
  - counter reaches STARVE_LIMIT at push+1+STARVE_LIMIT;
  - stall_req is high for exactly that one cycle, and the head pops in it;
  - stall_req drops the next cycle unless a new head has already waited STARVE_LIMIT.
- Full FIFO: lu_ready=0; the unit must hold lu_valid and its payload stable until accepted.
- Push and pop in the same cycle: occupancy is unchanged, and the head advances.
- Reset mid-operation: the next cycle shows the reset values, whatever the FIFO held.

## Structure
- Shared package: the pending-entry struct, GPR address width (7), HI/LO width (64), and register-address-0 constant.
- Sub-module wb_pending_fifo: parameterised DEPTH, with push/pop/full/empty and an exposed entry array for the q_hit compare.
- Arbiter, counter and output registers live in the top module.

## Test plan
- After reset, wb_we=1, wb_addr=5, wb_data=0x1234 → next cycle rf_we=1, rf_addr=5, rf_data=0x1234; all outputs 0 during reset.
- Idle pipeline, LU push {we=1, addr=9, data=0xABCD} at cycle N → rf_we/9/0xABCD at N+2; lu_ready stays 1.
- STARVE_LIMIT=4, continuous wb_we with one queued LU entry → stall_req high for exactly one cycle; that cycle's registered write is the LU entry; the held pipeline write follows next cycle.
- DEPTH=2, continuous pipeline writes, 3 LU offers → lu_ready drops after 2 pushes; the third is accepted the cycle after the first pop frees space.
- LU entry addr=12 queued, q_addr=12 → q_hit=1; q_addr=13 → 0; after drain → 0; queued addr=0 write → q_hit=0, rf_we=0.
- Two entries queued, rst pulsed for one cycle → FIFO empty; no rf_we in the following 5 idle cycles.

Source files
------------

// File: rtl/wb_port_arbiter_pkg.sv
// Shared types and constants for the writeback port arbiter.
package wb_port_arbiter_pkg;

  localparam int unsigned ADDR_W = 7;
  localparam int unsigned HILO_W = 64;
  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

  // Which source owns the write ports this cycle.
  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_PIPE,
    GNT_FIFO
  } grant_e;

  // Width-independent part of a pending long-latency result; the GPR data
  // field is appended by the top module because its width is a parameter.
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic              hilo_we;
    logic [HILO_W-1:0] hilo_data;
  } pend_meta_t;

  // A GPR write is only real when it targets a register other than r0.
  function automatic logic gpr_write(input logic we, input logic [ADDR_W-1:0] addr);
    return we && (addr != REG_ZERO);
  endfunction

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Bundle of pipeline, long-latency, write-port and hazard-query signals.
interface wb_port_arbiter_if
  import wb_port_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) ();

  logic              wb_we;
  logic [ADDR_W-1:0] wb_addr;
  logic [WIDTH-1:0]  wb_data;
  logic              wb_hilo_we;
  logic [HILO_W-1:0] wb_hilo_data;

  logic              lu_valid;
  logic              lu_ready;
  logic              lu_we;
  logic [ADDR_W-1:0] lu_addr;
  logic [WIDTH-1:0]  lu_data;
  logic              lu_hilo_we;
  logic [HILO_W-1:0] lu_hilo_data;

  logic              rf_we;
  logic [ADDR_W-1:0] rf_addr;
  logic [WIDTH-1:0]  rf_data;
  logic              hilo_we;
  logic [HILO_W-1:0] hilo_data;

  logic              stall_req;
  logic [ADDR_W-1:0] q_addr;
  logic              q_hit;

  // Arbiter side.
  modport slave (
    input  wb_we, wb_addr, wb_data, wb_hilo_we, wb_hilo_data,
    input  lu_valid, lu_we, lu_addr, lu_data, lu_hilo_we, lu_hilo_data,
    output lu_ready,
    output rf_we, rf_addr, rf_data, hilo_we, hilo_data,
    output stall_req, q_hit,
    input  q_addr
  );

  // Pipeline / long-latency unit / hazard unit side.
  modport master (
    output wb_we, wb_addr, wb_data, wb_hilo_we, wb_hilo_data,
    output lu_valid, lu_we, lu_addr, lu_data, lu_hilo_we, lu_hilo_data,
    input  lu_ready,
    input  rf_we, rf_addr, rf_data, hilo_we, hilo_data,
    input  stall_req, q_hit,
    output q_addr
  );

endinterface

// File: rtl/wb_pending_fifo.sv
// Circular pending-result FIFO with every slot and its valid bit exposed.
module wb_pending_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter type entry_t = logic
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  entry_t                 push_entry,
  input  logic                   pop,
  output entry_t                 head,
  output logic                   full,
  output logic                   empty,
  output entry_t [DEPTH-1:0]     entries,
  output logic   [DEPTH-1:0]     valid
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  entry_t [DEPTH-1:0] mem;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [CNT_W-1:0]   count;
  logic               do_push;
  logic               do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];
  assign entries = mem;

  // Pointer and occupancy bookkeeping; pointers wrap since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Payload storage; stale slots are masked by valid, so no reset is needed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_entry;
  end

  // A slot is live when its distance from the read pointer is below the occupancy.
  always_comb begin
    logic [PTR_W-1:0] off;
    valid = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      off      = PTR_W'(i) - rd_ptr;
      valid[i] = ({1'b0, off} < count);
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the GPR and HI/LO write ports between the in-order writeback stage
// and queued long-latency results, with a starvation-forced stall.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned DEPTH        = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic              clk,
  input logic              rst,
  wb_port_arbiter_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

  typedef struct packed {
    pend_meta_t       meta;
    logic [WIDTH-1:0] data;
  } entry_t;

  entry_t               push_entry;
  entry_t               head;
  entry_t [DEPTH-1:0]   entries;
  logic   [DEPTH-1:0]   valid;
  logic                 full;
  logic                 empty;
  logic                 push;
  logic                 pop;
  logic                 lu_ready;
  logic                 wb_req;
  logic                 stall;
  logic                 hit;
  logic [CNT_W-1:0]     starve_cnt;
  grant_e               grant;

  logic                 sel_we;
  logic [ADDR_W-1:0]    sel_addr;
  logic [WIDTH-1:0]     sel_data;
  logic                 sel_hilo_we;
  logic [HILO_W-1:0]    sel_hilo_data;

  assign lu_ready      = !full && !rst;
  assign push          = bus.lu_valid && lu_ready;
  assign wb_req        = bus.wb_we || bus.wb_hilo_we;
  assign stall         = (starve_cnt == CNT_W'(STARVE_LIMIT));
  assign pop           = (grant == GNT_FIFO);
  assign bus.lu_ready  = lu_ready;
  assign bus.stall_req = stall;
  assign bus.q_hit     = hit && !rst;

  // Pack the offered long-latency result into a FIFO entry.
  always_comb begin
    push_entry                = '0;
    push_entry.meta.we        = bus.lu_we;
    push_entry.meta.addr      = bus.lu_addr;
    push_entry.meta.hilo_we   = bus.lu_hilo_we;
    push_entry.meta.hilo_data = bus.lu_hilo_data;
    push_entry.data           = bus.lu_data;
  end

  wb_pending_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .full       (full),
    .empty      (empty),
    .entries    (entries),
    .valid      (valid)
  );

  // Port grant: a forced stall hands the port to the FIFO head, otherwise the pipeline wins.
  always_comb begin
    grant = GNT_NONE;
    if (stall && !empty)  grant = GNT_FIFO;
    else if (wb_req)      grant = GNT_PIPE;
    else if (!empty)      grant = GNT_FIFO;
  end

  // Mux the granted source's write fields; no grant yields an all-zero write.
  always_comb begin
    sel_we        = 1'b0;
    sel_addr      = '0;
    sel_data      = '0;
    sel_hilo_we   = 1'b0;
    sel_hilo_data = '0;
    unique case (grant)
      GNT_PIPE: begin
        sel_we        = bus.wb_we;
        sel_addr      = bus.wb_addr;
        sel_data      = bus.wb_data;
        sel_hilo_we   = bus.wb_hilo_we;
        sel_hilo_data = bus.wb_hilo_data;
      end
      GNT_FIFO: begin
        sel_we        = head.meta.we;
        sel_addr      = head.meta.addr;
        sel_data      = head.data;
        sel_hilo_we   = head.meta.hilo_we;
        sel_hilo_data = head.meta.hilo_data;
      end
      default: ;
    endcase
  end

  // Count how long the head has waited; saturates so stall_req stays a clean decode.
  always_ff @(posedge clk) begin
    if (rst || empty || pop) starve_cnt <= '0;
    else if (!stall)         starve_cnt <= starve_cnt + CNT_W'(1);
  end

  // Registered write ports; r0 writes are suppressed, HI/LO is independent.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.rf_we     <= 1'b0;
      bus.rf_addr   <= '0;
      bus.rf_data   <= '0;
      bus.hilo_we   <= 1'b0;
      bus.hilo_data <= '0;
    end else begin
      bus.rf_we     <= gpr_write(sel_we, sel_addr);
      bus.rf_addr   <= sel_addr;
      bus.rf_data   <= sel_data;
      bus.hilo_we   <= sel_hilo_we;
      bus.hilo_data <= sel_hilo_data;
    end
  end

  // Hazard query: does any queued entry still owe a write to q_addr.
  always_comb begin
    hit = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (valid[i] && gpr_write(entries[i].meta.we, entries[i].meta.addr) &&
          entries[i].meta.addr == bus.q_addr)
        hit = 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Randomised and directed bench for wb_port_arbiter against a queue-based model.
module tb_wb_port_arbiter;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned LIMIT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_port_arbiter_if #(.WIDTH(WIDTH)) bus ();

  wb_port_arbiter #(
    .WIDTH        (WIDTH),
    .DEPTH        (DEPTH),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        we;
    logic [6:0]  addr;
    logic [31:0] data;
    logic        hwe;
    logic [63:0] hdata;
  } ent_t;

  // Reference model state: pending results in arrival order, how long the
  // oldest has waited, and the write the ports should be showing.
  ent_t        mq[$];
  int unsigned waited = 0;
  logic        e_rf_we = 0;
  logic [6:0]  e_rf_addr = 0;
  logic [31:0] e_rf_data = 0;
  logic        e_hwe = 0;
  logic [63:0] e_hdata = 0;
  bit          m_wb_hold = 0;
  bit          m_lu_taken = 0;

  int vectors = 0;
  int errors  = 0;

  always @(posedge clk) begin : model
    ent_t g;
    bit   had;
    bit   can_push;
    int   src;
    if (rst) begin
      mq.delete();
      waited = 0;
      {e_rf_we, e_rf_addr, e_rf_data, e_hwe, e_hdata} = '0;
      m_wb_hold  = 0;
      m_lu_taken = 0;
    end else begin
      had      = (mq.size() != 0);
      can_push = (mq.size() < DEPTH);
      if (had && waited == LIMIT)            src = 1;
      else if (bus.wb_we || bus.wb_hilo_we)  src = 2;
      else if (had)                          src = 1;
      else                                   src = 0;
      if (src == 1)      g = mq.pop_front();
      else if (src == 2) g = '{bus.wb_we, bus.wb_addr, bus.wb_data, bus.wb_hilo_we, bus.wb_hilo_data};
      else               g = '{1'b0, 7'd0, 32'd0, 1'b0, 64'd0};
      e_rf_we   = g.we && (g.addr != 0);
      e_rf_addr = g.addr;
      e_rf_data = g.data;
      e_hwe     = g.hwe;
      e_hdata   = g.hdata;
      m_wb_hold  = (bus.wb_we || bus.wb_hilo_we) && (src != 2);
      m_lu_taken = bus.lu_valid && can_push;
      if (m_lu_taken)
        mq.push_back('{bus.lu_we, bus.lu_addr, bus.lu_data, bus.lu_hilo_we, bus.lu_hilo_data});
      if (had && src != 1) waited = (waited < LIMIT) ? waited + 1 : LIMIT;
      else                 waited = 0;
    end
  end

  function automatic logic [107:0] exp_vec();
    logic hit;
    hit = 1'b0;
    foreach (mq[i])
      if (mq[i].we && mq[i].addr == bus.q_addr && bus.q_addr != 0) hit = 1'b1;
    if (rst) hit = 1'b0;
    return {e_rf_we, e_rf_addr, e_rf_data, e_hwe, e_hdata,
            logic'(waited == LIMIT), logic'(!rst && mq.size() < DEPTH), hit};
  endfunction

  function automatic logic [107:0] obs_vec();
    return {bus.rf_we, bus.rf_addr, bus.rf_data, bus.hilo_we, bus.hilo_data,
            bus.stall_req, bus.lu_ready, bus.q_hit};
  endfunction

  task automatic idle_inputs();
    bus.wb_we = 0; bus.wb_addr = 0; bus.wb_data = 0;
    bus.wb_hilo_we = 0; bus.wb_hilo_data = 0;
    bus.lu_valid = 0; bus.lu_we = 0; bus.lu_addr = 0; bus.lu_data = 0;
    bus.lu_hilo_we = 0; bus.lu_hilo_data = 0;
    bus.q_addr = 0;
  endtask

  // Acts as the writeback stage: re-presents a request the arbiter stalled.
  task automatic drive_pipe(input bit force_req);
    if (m_wb_hold) return;
    bus.wb_we        = force_req ? 1'b1 : ($urandom_range(0, 9) < 5);
    bus.wb_addr      = force_req ? 7'($urandom_range(1, 31)) : 7'($urandom_range(0, 15));
    bus.wb_data      = $urandom;
    bus.wb_hilo_we   = ($urandom_range(0, 3) == 0);
    bus.wb_hilo_data = {$urandom, $urandom};
  endtask

  // Acts as the long-latency unit: holds an offer until it is accepted.
  task automatic drive_lu(input int pct);
    if (bus.lu_valid && !m_lu_taken) return;
    bus.lu_valid     = ($urandom_range(0, 99) < pct);
    bus.lu_we        = ($urandom_range(0, 3) != 0);
    bus.lu_addr      = 7'($urandom_range(0, 15));
    bus.lu_data      = $urandom;
    bus.lu_hilo_we   = ($urandom_range(0, 2) == 0);
    bus.lu_hilo_data = {$urandom, $urandom};
  endtask

  task automatic test_reset();
    rst = 1;
    idle_inputs();
    bus.wb_we = 1; bus.wb_addr = 5; bus.wb_data = 32'h1234; bus.lu_valid = 1;
    repeat (2) @(negedge clk);
    vectors++;
    if (obs_vec() !== '0) begin
      errors++; $display("FAIL reset_values got=%h exp=0", obs_vec());
    end
    vectors++;
    if (obs_vec() !== exp_vec()) begin
      errors++; $display("FAIL reset_model got=%h exp=%h", obs_vec(), exp_vec());
    end
    rst = 0;
    idle_inputs();
  endtask

  task automatic test_pipe_write();
    bus.wb_we = 1; bus.wb_addr = 5; bus.wb_data = 32'h1234;
    @(negedge clk);
    vectors++;
    if ({bus.rf_we, bus.rf_addr, bus.rf_data} !== {1'b1, 7'd5, 32'h1234}) begin
      errors++; $display("FAIL pipe_write got=%b/%0d/%h exp=1/5/1234", bus.rf_we, bus.rf_addr, bus.rf_data);
    end
    bus.wb_we = 0; bus.wb_addr = 0; bus.wb_hilo_we = 1; bus.wb_hilo_data = 64'hDEAD_BEEF_0BAD_F00D;
    @(negedge clk);
    vectors++;
    if ({bus.rf_we, bus.hilo_we, bus.hilo_data} !== {1'b0, 1'b1, 64'hDEAD_BEEF_0BAD_F00D}) begin
      errors++; $display("FAIL hilo_write got=%b/%b/%h exp=0/1/deadbeef0badf00d", bus.rf_we, bus.hilo_we, bus.hilo_data);
    end
    vectors++;
    if (obs_vec() !== exp_vec()) begin
      errors++; $display("FAIL pipe_model got=%h exp=%h", obs_vec(), exp_vec());
    end
    idle_inputs();
  endtask

  task automatic test_lu_idle();
    @(negedge clk);
    bus.lu_valid = 1; bus.lu_we = 1; bus.lu_addr = 9; bus.lu_data = 32'hABCD;
    #1;
    vectors++;
    if (bus.lu_ready !== 1'b1) begin
      errors++; $display("FAIL lu_ready_idle got=%b exp=1", bus.lu_ready);
    end
    @(negedge clk);
    bus.lu_valid = 0;
    vectors++;
    if (bus.rf_we !== 1'b0) begin
      errors++; $display("FAIL lu_no_bypass got rf_we=%b exp=0", bus.rf_we);
    end
    @(negedge clk);
    vectors++;
    if ({bus.rf_we, bus.rf_addr, bus.rf_data, bus.lu_ready} !== {1'b1, 7'd9, 32'hABCD, 1'b1}) begin
      errors++; $display("FAIL lu_latency got=%b/%0d/%h rdy=%b exp=1/9/abcd rdy=1", bus.rf_we, bus.rf_addr, bus.rf_data, bus.lu_ready);
    end
    vectors++;
    if (obs_vec() !== exp_vec()) begin
      errors++; $display("FAIL lu_model got=%h exp=%h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_starve();
    int          stalls = 0;
    int          stall_at = -10;
    logic [31:0] lu_d;
    logic [6:0]  held_addr = 0;
    lu_d = $urandom;
    drive_pipe(1);
    bus.lu_valid = 1; bus.lu_we = 1; bus.lu_addr = 21; bus.lu_data = lu_d;
    bus.lu_hilo_we = 0; bus.lu_hilo_data = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL starve_model c=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
      end
      if (bus.stall_req === 1'b1) begin stalls++; stall_at = c; end
      if (c == stall_at + 1) begin
        vectors++;
        if ({bus.rf_we, bus.rf_addr, bus.rf_data} !== {1'b1, 7'd21, lu_d}) begin
          errors++; $display("FAIL starve_lu_write got=%b/%0d/%h exp=1/21/%h", bus.rf_we, bus.rf_addr, bus.rf_data, lu_d);
        end
        held_addr = bus.wb_addr;
      end
      if (c == stall_at + 2) begin
        vectors++;
        if ({bus.rf_we, bus.rf_addr} !== {1'b1, held_addr}) begin
          errors++; $display("FAIL starve_held_pipe got=%b/%0d exp=1/%0d", bus.rf_we, bus.rf_addr, held_addr);
        end
      end
      if (m_lu_taken) bus.lu_valid = 0;
      drive_pipe(1);
    end
    vectors++;
    if (stalls !== 1) begin
      errors++; $display("FAIL starve_stall_count got=%0d exp=1", stalls);
    end
  endtask

  task automatic test_full();
    int offers = 0, accepted = 0, pop_c = -1, third_c = -1;
    bit saw_block = 0;
    for (int c = 0; c < 40 && accepted < 3; c++) begin
      @(negedge clk);
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL full_model c=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
      end
      if (m_lu_taken && bus.lu_valid) begin
        accepted++;
        if (accepted == 3) third_c = c;
      end
      if (bus.lu_valid && !bus.lu_ready) saw_block = 1;
      if (bus.stall_req && pop_c < 0) pop_c = c;
      drive_pipe(1);
      if (!(bus.lu_valid && !m_lu_taken)) begin
        if (offers < 3) begin drive_lu(100); offers++; end
        else bus.lu_valid = 0;
      end
    end
    bus.lu_valid = 0;
    vectors++;
    if (accepted !== 3 || saw_block !== 1'b1) begin
      errors++; $display("FAIL full_backpressure accepted=%0d blocked=%b exp=3/1", accepted, saw_block);
    end
    vectors++;
    if (third_c !== pop_c + 2) begin
      errors++; $display("FAIL full_third_accept got=%0d exp=%0d", third_c, pop_c + 2);
    end
    idle_inputs();
    repeat (4) begin
      @(negedge clk);
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL full_drain got=%h exp=%h", obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_qhit();
    drive_pipe(1);
    bus.lu_valid = 1; bus.lu_we = 1; bus.lu_addr = 12; bus.lu_data = $urandom;
    @(negedge clk);
    bus.lu_valid = 0;
    drive_pipe(1);
    bus.q_addr = 12; #1;
    vectors++;
    if (bus.q_hit !== 1'b1) begin errors++; $display("FAIL qhit_match got=%b exp=1", bus.q_hit); end
    bus.q_addr = 13; #1;
    vectors++;
    if (bus.q_hit !== 1'b0) begin errors++; $display("FAIL qhit_other got=%b exp=0", bus.q_hit); end
    vectors++;
    if (obs_vec() !== exp_vec()) begin errors++; $display("FAIL qhit_model got=%h exp=%h", obs_vec(), exp_vec()); end
    bus.wb_we = 0; bus.wb_hilo_we = 0;
    repeat (3) @(negedge clk);
    bus.q_addr = 12; #1;
    vectors++;
    if (bus.q_hit !== 1'b0) begin errors++; $display("FAIL qhit_drained got=%b exp=0", bus.q_hit); end
    drive_pipe(1);
    bus.lu_valid = 1; bus.lu_we = 1; bus.lu_addr = 0; bus.lu_data = 32'h5555;
    @(negedge clk);
    bus.lu_valid = 0;
    bus.q_addr = 0; #1;
    vectors++;
    if (bus.q_hit !== 1'b0) begin errors++; $display("FAIL qhit_r0 got=%b exp=0", bus.q_hit); end
    bus.wb_we = 0; bus.wb_hilo_we = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k >= 1) begin
        vectors++;
        if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL r0_write k=%0d got rf_we=%b exp=0", k, bus.rf_we); end
      end
      vectors++;
      if (obs_vec() !== exp_vec()) begin errors++; $display("FAIL r0_model k=%0d got=%h exp=%h", k, obs_vec(), exp_vec()); end
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    int guard = 0;
    drive_pipe(1);
    drive_lu(100);
    while (mq.size() < 2 && guard < 10) begin
      @(negedge clk);
      guard++;
      vectors++;
      if (obs_vec() !== exp_vec()) begin errors++; $display("FAIL rstmid_fill got=%h exp=%h", obs_vec(), exp_vec()); end
      drive_pipe(1);
      drive_lu(100);
    end
    vectors++;
    if (mq.size() != 2) begin errors++; $display("FAIL rstmid_timeout queued=%0d exp=2", mq.size()); end
    rst = 1;
    idle_inputs();
    #1;
    vectors++;
    if ({bus.lu_ready, bus.q_hit} !== 2'b00) begin errors++; $display("FAIL rstmid_comb got=%b exp=00", {bus.lu_ready, bus.q_hit}); end
    @(negedge clk);
    rst = 0;
    vectors++;
    if (obs_vec() !== '0) begin errors++; $display("FAIL rstmid_values got=%h exp=0", obs_vec()); end
    repeat (5) begin
      @(negedge clk);
      vectors++;
      if (bus.rf_we !== 1'b0 || obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL rstmid_idle got=%h exp=%h", obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_random(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL random c=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
      end
      rst = ($urandom_range(0, 99) == 0);
      drive_pipe(0);
      drive_lu(45);
      bus.q_addr = 7'($urandom_range(0, 15));
      #1;
      vectors++;
      if ({bus.lu_ready, bus.q_hit} !== exp_vec()[1:0]) begin
        errors++; $display("FAIL random_comb c=%0d got=%b exp=%b", c, {bus.lu_ready, bus.q_hit}, exp_vec()[1:0]);
      end
    end
    rst = 0;
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_pipe_write();
    test_lu_idle();
    test_starve();
    test_full();
    test_qhit();
    test_reset_mid();
    test_random(400);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
